filt_ppi_mac_sched: RTL and testbench

//  Scheduler for a time-multiplexed polyphase interpolator: one shared MAC serves all L phases.

---
 rtl/filt_ppi_mac_sched_pkg.sv | 23 ++
 rtl/filt_ppi_mac_sched_cnt.sv | 39 +++
 rtl/filt_ppi_mac_sched.sv | 185 ++++++++++++++++++
 tb/tb_filt_ppi_mac_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_ppi_mac_sched_pkg.sv
// Shared types and elaboration-time helpers for the polyphase interpolator MAC scheduler.
package filt_ppi_mac_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic int f_ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int f_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // (a - b) mod m for 0 <= a,b < m; avoids relying on a power-of-two wrap
  function automatic int f_mod_sub(input int a, input int b, input int m);
    return (a >= b) ? (a - b) : (a + m - b);
  endfunction

endpackage

// File: rtl/filt_ppi_mac_sched_cnt.sv
// Modulo-M up/down counter with load, enable and a look-ahead next value / wrap flag.
module filt_ppi_sched_cnt
  import filt_ppi_mac_sched_pkg::*;
#(
  parameter int M       = 7,
  parameter int W       = 3,
  parameter int RST_VAL = 0
)(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  localparam logic [W-1:0] MAX_VAL = W'(M - 1);
  localparam logic [W-1:0] RST_V   = W'(RST_VAL);

  logic [W-1:0] r_cnt;

  always_comb begin
    o_wrap = i_up ? (r_cnt == MAX_VAL) : (r_cnt == '0);
    if (i_up) o_next = o_wrap ? '0 : r_cnt + W'(1);
    else      o_next = o_wrap ? MAX_VAL : r_cnt - W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cnt <= RST_V;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en)   r_cnt <= o_next;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/filt_ppi_mac_sched.sv
// Polyphase interpolator scheduler: one sample in, L phases x K taps of MAC strobes out.
// Optional drop counter enabled by defining FILT_PPI_MAC_SCHED_DROP_CNT_EN.
module filt_ppi_mac_sched
  import filt_ppi_mac_sched_pkg::*;
#(
  parameter int gp_interpolation_factor = 8,
  parameter int gp_coeff_length         = 53,
  parameter int gp_comm_phase           = 0,
  parameter int gp_ccw                  = 1,
  localparam int L  = gp_interpolation_factor,
  localparam int K  = f_ceil_div(gp_coeff_length, gp_interpolation_factor),
  localparam int KW = f_width(K),
  localparam int LW = f_width(L),
  localparam int CW = f_width(L * K)
)(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ena,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_dl_we,
  output logic [KW-1:0] o_dl_addr,
  output logic [CW-1:0] o_coef_addr,
  output logic          o_mac_clr,
  output logic          o_mac_en,
  output logic          o_mac_last,
  output logic [LW-1:0] o_phase,
  output logic [15:0]   o_drop_cnt
);

  localparam logic [LW-1:0] COMM_PH = LW'(gp_comm_phase);
  localparam logic [LW-1:0] LAST_PH = LW'((gp_ccw != 0) ? (gp_comm_phase + L - 1) % L
                                                        : (gp_comm_phase + 1) % L);
  localparam logic [KW-1:0] LAST_TAP = KW'(K - 1);

  state_t        r_state;
  logic [KW-1:0] r_wr_last;
  logic          r_dl_we;
  logic [KW-1:0] r_dl_addr;
  logic [CW-1:0] r_coef_addr;
  logic          r_mac_clr;
  logic          r_mac_en;
  logic          r_mac_last;
  logic [LW-1:0] r_phase;

  logic [KW-1:0] w_tap, w_tap_next;
  logic          w_tap_wrap;
  logic [LW-1:0] w_phase, w_phase_next;
  logic          w_phase_wrap;
  logic [KW-1:0] w_wptr, w_wptr_next;
  logic          w_wptr_wrap;
  logic          w_run, w_load, w_done;
  logic [KW-1:0] w_iss_tap;
  logic [LW-1:0] w_iss_phase;
  logic [KW-1:0] w_rd_addr;
  logic [CW-1:0] w_coef;
  logic          w_unused_cnt;

  assign w_run  = i_ena && (r_state == ST_RUN);
  assign w_load = i_ena && (r_state == ST_LOAD);

  filt_ppi_sched_cnt #(.M(K), .W(KW), .RST_VAL(0)) u_tap_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_run),
    .i_up       (1'b1),
    .i_load     (w_load),
    .i_load_val ('0),
    .o_cnt      (w_tap),
    .o_next     (w_tap_next),
    .o_wrap     (w_tap_wrap)
  );

  filt_ppi_sched_cnt #(.M(L), .W(LW), .RST_VAL(gp_comm_phase)) u_phase_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_run && w_tap_wrap),
    .i_up       (gp_ccw != 0),
    .i_load     (w_load),
    .i_load_val (COMM_PH),
    .o_cnt      (w_phase),
    .o_next     (w_phase_next),
    .o_wrap     (w_phase_wrap)
  );

  filt_ppi_sched_cnt #(.M(K), .W(KW), .RST_VAL(0)) u_wptr_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_load),
    .i_up       (1'b1),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_cnt      (w_wptr),
    .o_next     (w_wptr_next),
    .o_wrap     (w_wptr_wrap)
  );

  assign w_unused_cnt = ^{w_phase_wrap, w_wptr_next, w_wptr_wrap, w_tap == LAST_TAP};

  // Outputs are registered, so they are computed from the tap/phase the counters step to
  always_comb begin
    w_iss_tap   = w_tap_next;
    w_iss_phase = w_tap_wrap ? w_phase_next : w_phase;
    if (r_state == ST_LOAD) begin
      w_iss_tap   = '0;
      w_iss_phase = COMM_PH;
    end
    w_rd_addr = KW'(f_mod_sub(int'(r_wr_last), int'(w_iss_tap), K));
    w_coef    = CW'(int'(w_iss_phase) * K + int'(w_iss_tap));
    w_done    = (r_state == ST_RUN) && w_tap_wrap && (w_phase == LAST_PH);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_wr_last   <= '0;
      r_dl_we     <= 1'b0;
      r_dl_addr   <= '0;
      r_coef_addr <= '0;
      r_mac_clr   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_last  <= 1'b0;
      r_phase     <= COMM_PH;
    end else if (!i_ena) begin
      r_dl_we    <= 1'b0;
      r_mac_clr  <= 1'b0;
      r_mac_en   <= 1'b0;
      r_mac_last <= 1'b0;
    end else begin
      r_dl_we    <= 1'b0;
      r_mac_clr  <= 1'b0;
      r_mac_en   <= 1'b0;
      r_mac_last <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_state   <= ST_LOAD;
            r_dl_we   <= 1'b1;
            r_dl_addr <= w_wptr;
            r_wr_last <= w_wptr;
          end
        end
        ST_LOAD, ST_RUN: begin
          if (w_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_state     <= ST_RUN;
            r_dl_addr   <= w_rd_addr;
            r_coef_addr <= w_coef;
            r_phase     <= w_iss_phase;
            r_mac_en    <= 1'b1;
            r_mac_clr   <= (w_iss_tap == '0);
            r_mac_last  <= (w_iss_tap == LAST_TAP);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready     = (r_state == ST_IDLE);
  assign o_dl_we     = r_dl_we;
  assign o_dl_addr   = r_dl_addr;
  assign o_coef_addr = r_coef_addr;
  assign o_mac_clr   = r_mac_clr;
  assign o_mac_en    = r_mac_en;
  assign o_mac_last  = r_mac_last;
  assign o_phase     = r_phase;

`ifdef FILT_PPI_MAC_SCHED_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_drop_cnt <= 16'd0;
    else if (i_ena && i_valid && !o_ready && (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_filt_ppi_mac_sched.sv
// Bench for filt_ppi_mac_sched: two parameterisations driven in lockstep against a schedule-level model.
module tb_filt_ppi_mac_sched;

  localparam int L  = 8;
  localparam int K  = 7;
  localparam int LK = L * K;
`ifdef FILT_PPI_MAC_SCHED_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, ena, valid;

  logic a_ready, a_we, a_clr, a_en, a_last;
  logic [2:0] a_dl_addr, a_phase;
  logic [5:0] a_coef;
  logic [15:0] a_drop;
  logic b_ready, b_we, b_clr, b_en, b_last;
  logic [2:0] b_dl_addr, b_phase;
  logic [5:0] b_coef;
  logic [15:0] b_drop;

  filt_ppi_mac_sched #(.gp_interpolation_factor(8), .gp_coeff_length(53),
                       .gp_comm_phase(0), .gp_ccw(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(valid),
    .o_ready(a_ready), .o_dl_we(a_we), .o_dl_addr(a_dl_addr), .o_coef_addr(a_coef),
    .o_mac_clr(a_clr), .o_mac_en(a_en), .o_mac_last(a_last), .o_phase(a_phase),
    .o_drop_cnt(a_drop)
  );

  filt_ppi_mac_sched #(.gp_interpolation_factor(8), .gp_coeff_length(53),
                       .gp_comm_phase(3), .gp_ccw(0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(valid),
    .o_ready(b_ready), .o_dl_we(b_we), .o_dl_addr(b_dl_addr), .o_coef_addr(b_coef),
    .o_mac_clr(b_clr), .o_mac_en(b_en), .o_mac_last(b_last), .o_phase(b_phase),
    .o_drop_cnt(b_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: stage -1 idle, 0 write cycle, s>0 means issue number s-1 is on the outputs
  int m_stage[2], m_wptr[2], m_wlast[2], m_dl[2], m_coef[2], m_phase[2], m_drop[2];
  bit m_ready[2], m_we[2], m_en[2], m_clr[2], m_last[2];

  function automatic int comm_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_stage[d] = -1; m_wptr[d] = 0; m_wlast[d] = 0;
      m_dl[d] = 0; m_coef[d] = 0; m_phase[d] = comm_of(d); m_drop[d] = 0;
      m_ready[d] = 1; m_we[d] = 0; m_en[d] = 0; m_clr[d] = 0; m_last[d] = 0;
    end
  endtask

  task automatic model_step();
    int j, tap, grp, ph;
    for (int d = 0; d < 2; d++) begin
      m_we[d] = 0; m_en[d] = 0; m_clr[d] = 0; m_last[d] = 0;
      if (ena) begin
        if (DROP_EN && valid && m_stage[d] != -1 && m_drop[d] < 65535) m_drop[d]++;
        if (m_stage[d] == -1) begin
          if (valid) begin
            m_stage[d] = 0;
            m_we[d] = 1;
            m_dl[d] = m_wptr[d];
            m_wlast[d] = m_wptr[d];
            m_wptr[d] = (m_wptr[d] + 1) % K;
          end
        end else if (m_stage[d] < LK) begin
          j = m_stage[d];
          tap = j % K;
          grp = j / K;
          ph = (d == 0) ? (comm_of(d) + grp) % L : (comm_of(d) - grp + L) % L;
          m_en[d] = 1;
          m_clr[d] = (tap == 0);
          m_last[d] = (tap == K - 1);
          m_dl[d] = (m_wlast[d] - tap + K) % K;
          m_coef[d] = ph * K + tap;
          m_phase[d] = ph;
          m_stage[d]++;
        end else begin
          m_stage[d] = -1;
        end
      end
      m_ready[d] = (m_stage[d] == -1);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic cmp_dut(input string p, input int d, input logic rdy, input logic we,
                         input logic en, input logic clr, input logic last,
                         input logic [2:0] dl, input logic [5:0] coef,
                         input logic [2:0] ph, input logic [15:0] drop);
    chk({p, ".ready"}, rdy, m_ready[d]);
    chk({p, ".dl_we"}, we, m_we[d]);
    chk({p, ".mac_en"}, en, m_en[d]);
    chk({p, ".mac_clr"}, clr, m_clr[d]);
    chk({p, ".mac_last"}, last, m_last[d]);
    chk({p, ".drop_cnt"}, drop, m_drop[d]);
    if (m_we[d] || m_en[d]) chk({p, ".dl_addr"}, dl, m_dl[d]);
    if (m_en[d]) begin
      chk({p, ".coef_addr"}, coef, m_coef[d]);
      chk({p, ".phase"}, ph, m_phase[d]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_dut("A", 0, a_ready, a_we, a_en, a_clr, a_last, a_dl_addr, a_coef, a_phase, a_drop);
      cmp_dut("B", 1, b_ready, b_we, b_en, b_clr, b_last, b_dl_addr, b_coef, b_phase, b_drop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!a_ready && n < 300) begin
      tick();
      n++;
    end
    chk("wait_idle_budget", a_ready, 1);
  endtask

  int n_en, n_clr, n_last, first_en, last_en, bad, nb, idx, first_after, coef_after, gap_bad, n_we;
  int bph[8], bco[8], we_at[4];
  int exp_dl[7], exp_bph[8], exp_bco[8];

  initial begin
    exp_dl  = '{1, 0, 6, 5, 4, 3, 2};
    exp_bph = '{3, 2, 1, 0, 7, 6, 5, 4};
    exp_bco = '{21, 14, 7, 0, 49, 42, 35, 28};

    rst = 1'b1; ena = 1'b1; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", a_ready, 1);
    chk("rst.phase_a", a_phase, 0);
    chk("rst.phase_b", b_phase, 3);
    chk("rst.strobes", {a_we, a_en, a_clr, a_last}, 0);
    chk("rst.addrs", {a_dl_addr, a_coef}, 0);
    chk("rst.drop", a_drop, 0);
    rst = 1'b0;
    tick(); tick();

    // single sample accepted in cycle 0
    n_en = 0; n_clr = 0; n_last = 0; first_en = -1; last_en = -1; bad = 0; nb = 0;
    valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) begin
        chk("t1.we_at_1", a_we, 1);
        chk("t1.wr_addr_at_1", a_dl_addr, 0);
        valid = 1'b0;
      end
      if (a_en) begin
        n_en++;
        if (first_en < 0) first_en = c;
        last_en = c;
      end
      if (a_clr) begin
        n_clr++;
        if ((c - 2) % 7 != 0) bad++;
      end
      if (a_last) begin
        n_last++;
        if ((c - 8) % 7 != 0) bad++;
      end
      if (b_clr && nb < 8) begin
        bph[nb] = b_phase;
        bco[nb] = b_coef;
        nb++;
      end
      if (c == 57) chk("t1.ready_at_57", a_ready, 0);
      if (c == 58) chk("t1.ready_at_58", a_ready, 1);
    end
    chk("t1.en_count", n_en, 56);
    chk("t1.first_en", first_en, 2);
    chk("t1.last_en", last_en, 57);
    chk("t1.clr_count", n_clr, 8);
    chk("t1.last_count", n_last, 8);
    chk("t1.strobe_slots", bad, 0);
    chk("t1.b_pass_count", nb, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1.b_phase[%0d]", i), bph[i], exp_bph[i]);
      chk($sformatf("t1.b_coef_base[%0d]", i), bco[i], exp_bco[i]);
    end

    // second sample: read order newest first, coefficients walk 0..55
    idx = 0; bad = 0;
    valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) valid = 1'b0;
      if (a_en) begin
        if (idx < 7) chk($sformatf("t2.dl_addr[%0d]", idx), a_dl_addr, exp_dl[idx]);
        if (a_coef != 6'(idx)) bad++;
        idx++;
      end
    end
    chk("t2.coef_walk", bad, 0);
    chk("t2.issue_count", idx, 56);

    // i_ena low for 5 cycles just before tap 3 of phase 2 would issue
    first_after = -1; coef_after = -1; gap_bad = 0;
    valid = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (c == 1) valid = 1'b0;
      if (c >= 19 && c <= 23 && a_en) gap_bad++;
      if (c >= 24 && first_after < 0 && a_en) begin
        first_after = c;
        coef_after = a_coef;
      end
      if (c == 62) chk("t3.ready_at_62", a_ready, 0);
      if (c == 63) chk("t3.ready_at_63", a_ready, 1);
      if (c == 18) ena = 1'b0;
      if (c == 23) ena = 1'b1;
    end
    chk("t3.frozen", gap_bad, 0);
    chk("t3.resume_cycle", first_after, 24);
    chk("t3.resume_coef", coef_after, 17);

    // continuous valid for three samples
    n_we = 0;
    valid = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (c == 117) valid = 1'b0;
      if (a_we) begin
        if (n_we < 4) we_at[n_we] = c;
        n_we++;
      end
    end
    chk("t4.accepts", n_we, 3);
    if (n_we >= 3) begin
      chk("t4.accept0", we_at[0], 1);
      chk("t4.accept1", we_at[1], 59);
      chk("t4.accept2", we_at[2], 117);
    end
`ifdef FILT_PPI_MAC_SCHED_DROP_CNT_EN
    chk("t4.drop_cnt", a_drop, m_drop[0]);
`else
    chk("t4.drop_cnt", a_drop, 0);
`endif
    wait_idle();

    // reset pulse mid-run returns to idle with write pointer 0
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (20) tick();
    chk("t5.busy_before_rst", a_ready, 0);
    rst = 1'b1;
    #1;
    chk("t5.ready_in_rst", a_ready, 1);
    chk("t5.en_in_rst", a_en, 0);
    tick();
    rst = 1'b0;
    tick();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("t5.we_after_rst", a_we, 1);
    chk("t5.wptr_after_rst", a_dl_addr, 0);
    wait_idle();

    // randomized traffic, enable gaps and rare resets
    for (int c = 0; c < 4000; c++) begin
      valid = ($urandom_range(0, 3) == 0);
      ena   = ($urandom_range(0, 7) != 0);
      rst   = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; ena = 1'b1; valid = 1'b0;
    tick();
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
